// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU commit stage: register file, PC, load/store sequencing, retire count
//
// Purpose: commits ALU results to the two architectural registers (reg_a/reg_b),
// resolves beq/bne, runs lw/sw over a req/ack memory port and counts retired
// instructions. Optional overflow trap enabled by defining ALU_WB_TRAP_EN.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_ready            instruction beat handshake (in_ready comb)
//   instruction, result, flags   executed instruction, ALU result, ALU flags
//   reg_a, reg_b                 architectural registers 0 and 1
//   pc                           program counter (word addressed)
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_ack/mem_rdata  memory request port, request held until ack
//   status_flags                 flags of last committed instruction
//   retire_cnt                   committed instruction count (wraps)
//   trap, trap_clr               overflow trap pending / clear
module alu_writeback #(
  parameter int          PC_W     = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic [31:0]      result,
  input  logic [2:0]       flags,
  output logic [31:0]      reg_a,
  output logic [31:0]      reg_b,
  output logic [PC_W-1:0]  pc,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [2:0]       status_flags,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             trap,
  input  logic             trap_clr
);

`ifdef ALU_WB_TRAP_EN
  typedef enum logic [1:0] {S_IDLE, S_MEM_WAIT, S_TRAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MEM_WAIT} state_t;
`endif

  state_t            r_state;
  logic [31:0]       r_reg_a, r_reg_b;
  logic [PC_W-1:0]   r_pc;
  logic              r_mem_req, r_mem_we;
  logic [31:0]       r_mem_addr, r_mem_wdata;
  logic [2:0]        r_status_flags;
  logic [CNT_W-1:0]  r_retire_cnt;
  logic              r_trap;
  // Load destination and flags held across MEM_WAIT so the commit uses accept-time values
  logic              r_mem_dest_wr;
  logic [4:0]        r_mem_dest_idx;
  logic [2:0]        r_mem_flags;

  logic [5:0]        w_op, w_func;
  logic              w_is_lw, w_is_sw, w_is_br, w_br_taken, w_ovf_op, w_accept;
  logic              w_dest_wr;
  logic [4:0]        w_dest_idx;
  logic [31:0]       w_rt_val;
  logic [31:0]       w_br_sum;
  logic [PC_W-1:0]   w_pc_seq;

  assign w_op     = instruction[31:26];
  assign w_func   = instruction[5:0];
  assign w_is_lw  = (w_op == 6'b100011);
  assign w_is_sw  = (w_op == 6'b101011);
  assign w_is_br  = (w_op == 6'b000100) || (w_op == 6'b000101);
  assign w_ovf_op = ((w_op == 6'b000000) && ((w_func == 6'b100000) || (w_func == 6'b100010)))
                  || (w_op == 6'b001000);
  // flags[0] set means "zero/not-taken" for the branch compare
  assign w_br_taken = w_is_br && !flags[0];
  assign w_accept   = in_valid && (r_state == S_IDLE);
  assign w_pc_seq   = r_pc + PC_W'(1);
  // Full-width sum, then truncate: the taken target wraps modulo 2^PC_W
  assign w_br_sum   = 32'(r_pc) + 32'd1 + {{16{result[15]}}, result[15:0]};

  always_comb begin
    w_dest_wr  = 1'b0;
    w_dest_idx = instruction[20:16];
    case (w_op)
      6'b000000: begin
        w_dest_wr  = 1'b1;
        w_dest_idx = instruction[15:11];
      end
      6'b001000, 6'b001001, 6'b001100, 6'b001101,
      6'b001110, 6'b001010, 6'b001011, 6'b100011: w_dest_wr = 1'b1;
      default: w_dest_wr = 1'b0;
    endcase
  end

  always_comb begin
    case (instruction[20:16])
      5'd0:    w_rt_val = r_reg_a;
      5'd1:    w_rt_val = r_reg_b;
      default: w_rt_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_reg_a        <= '0;
      r_reg_b        <= '0;
      r_pc           <= PC_W'(RESET_PC);
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_status_flags <= '0;
      r_retire_cnt   <= '0;
      r_trap         <= 1'b0;
      r_mem_dest_wr  <= 1'b0;
      r_mem_dest_idx <= '0;
      r_mem_flags    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
`ifdef ALU_WB_TRAP_EN
            if (w_ovf_op && flags[2]) begin
              r_status_flags <= flags;
              r_trap         <= 1'b1;
              r_state        <= S_TRAP;
            end else
`endif
            if (w_is_lw || w_is_sw) begin
              r_mem_req      <= 1'b1;
              r_mem_we       <= w_is_sw;
              r_mem_addr     <= result;
              r_mem_wdata    <= w_rt_val;
              r_mem_dest_wr  <= w_is_lw;
              r_mem_dest_idx <= w_dest_idx;
              r_mem_flags    <= flags;
              r_state        <= S_MEM_WAIT;
            end else begin
              if (w_dest_wr && (w_dest_idx == 5'd0)) r_reg_a <= result;
              if (w_dest_wr && (w_dest_idx == 5'd1)) r_reg_b <= result;
              r_status_flags <= flags;
              r_retire_cnt   <= r_retire_cnt + CNT_W'(1);
              r_pc           <= w_br_taken ? w_br_sum[PC_W-1:0] : w_pc_seq;
            end
          end
        end
        S_MEM_WAIT: begin
          if (mem_ack) begin
            if (r_mem_dest_wr && (r_mem_dest_idx == 5'd0)) r_reg_a <= mem_rdata;
            if (r_mem_dest_wr && (r_mem_dest_idx == 5'd1)) r_reg_b <= mem_rdata;
            r_pc           <= w_pc_seq;
            r_retire_cnt   <= r_retire_cnt + CNT_W'(1);
            r_status_flags <= r_mem_flags;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
`ifdef ALU_WB_TRAP_EN
        S_TRAP: begin
          if (trap_clr) begin
            r_trap  <= 1'b0;
            r_pc    <= w_pc_seq;
            r_state <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = (r_state == S_IDLE);
  assign reg_a        = r_reg_a;
  assign reg_b        = r_reg_b;
  assign pc           = r_pc;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign status_flags = r_status_flags;
  assign retire_cnt   = r_retire_cnt;

`ifdef ALU_WB_TRAP_EN
  assign trap = r_trap;
  logic w_unused;
  assign w_unused = ^{instruction[25:21], instruction[10:6]};
`else
  assign trap = 1'b0;
  logic w_unused;
  assign w_unused = ^{instruction[25:21], instruction[10:6], trap_clr, r_trap, w_ovf_op};
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - self-checking bench for alu_writeback
module tb_alu_writeback;

  localparam int PC_W  = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      instruction = '0;
  logic [31:0]      result = '0;
  logic [2:0]       flags = '0;
  logic [31:0]      reg_a, reg_b;
  logic [PC_W-1:0]  pc;
  logic             mem_req, mem_we;
  logic [31:0]      mem_addr, mem_wdata;
  logic             mem_ack = 1'b0;
  logic [31:0]      mem_rdata = '0;
  logic [2:0]       status_flags;
  logic [CNT_W-1:0] retire_cnt;
  logic             trap;
  logic             trap_clr = 1'b0;

  alu_writeback #(.PC_W(PC_W), .RESET_PC(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .result(result), .flags(flags),
    .reg_a(reg_a), .reg_b(reg_b), .pc(pc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .status_flags(status_flags), .retire_cnt(retire_cnt),
    .trap(trap), .trap_clr(trap_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       fl;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]      m_a = '0, m_b = '0;
  logic [PC_W-1:0]  m_pc = '0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic [2:0]       m_fl = '0;

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {op, 5'd3, rt, rd, 5'd0, fn};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model();
    exp_t e;
    e.a = m_a; e.b = m_b; e.pc = m_pc; e.cnt = m_cnt; e.fl = m_fl;
    sb.push_back(e);
  endtask

  task automatic model_write(input logic [31:0] ins, input logic [31:0] val);
    logic [5:0] op;
    logic [4:0] d;
    bit wr;
    op = ins[31:26];
    wr = 0;
    d  = ins[20:16];
    if (op == 6'h00) begin wr = 1; d = ins[15:11]; end
    else if (op inside {6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h23}) wr = 1;
    if (wr && d == 5'd0) m_a = val;
    if (wr && d == 5'd1) m_b = val;
  endtask

  task automatic sb_drain(input string name);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty got=none exp=entry", name);
      return;
    end
    e = sb.pop_front();
    if (reg_a !== e.a) begin n_bad++; $display("FAIL %s reg_a: got=%h exp=%h", name, reg_a, e.a); end
    n_cmp++;
    if (reg_b !== e.b) begin n_bad++; $display("FAIL %s reg_b: got=%h exp=%h", name, reg_b, e.b); end
    n_cmp++;
    if (pc !== e.pc) begin n_bad++; $display("FAIL %s pc: got=%h exp=%h", name, pc, e.pc); end
    n_cmp++;
    if (retire_cnt !== e.cnt) begin n_bad++; $display("FAIL %s retire_cnt: got=%h exp=%h", name, retire_cnt, e.cnt); end
    n_cmp++;
    if (status_flags !== e.fl) begin n_bad++; $display("FAIL %s status_flags: got=%b exp=%b", name, status_flags, e.fl); end
  endtask

  // Drives one non-memory beat; leaves in_valid high so consecutive calls are back-to-back
  task automatic issue_alu(input string name, input logic [31:0] ins,
                           input logic [31:0] res, input logic [2:0] fl);
    logic [5:0] op;
    op = ins[31:26];
    model_write(ins, res);
    if ((op == 6'h04 || op == 6'h05) && !fl[0]) m_pc = m_pc + 16'd1 + res[15:0];
    else m_pc = m_pc + 16'd1;
    m_cnt = m_cnt + 1'b1;
    m_fl  = fl;
    push_model();
    in_valid = 1'b1; instruction = ins; result = res; flags = fl;
    step();
    sb_drain(name);
  endtask

  task automatic issue_mem(input string name, input logic [31:0] ins, input logic [31:0] res,
                           input logic [2:0] fl, input logic [31:0] rdata, input int delay);
    bit is_sw;
    logic [31:0] exp_wd;
    is_sw = (ins[31:26] == 6'h2B);
    exp_wd = (ins[20:16] == 5'd0) ? m_a : (ins[20:16] == 5'd1) ? m_b : 32'h0;
    if (!is_sw) model_write(ins, rdata);
    m_pc = m_pc + 16'd1;
    m_cnt = m_cnt + 1'b1;
    m_fl = fl;
    push_model();
    in_valid = 1'b1; instruction = ins; result = res; flags = fl;
    step();
    in_valid = 1'b0; flags = 3'b000; result = 32'hFFFF_FFFF;
    for (int i = 0; i < delay; i++) begin
      n_cmp++;
      if (mem_req !== 1'b1) begin n_bad++; $display("FAIL %s mem_req[%0d]: got=%b exp=1", name, i, mem_req); end
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL %s in_ready[%0d]: got=%b exp=0", name, i, in_ready); end
      n_cmp++;
      if (mem_addr !== res) begin n_bad++; $display("FAIL %s mem_addr: got=%h exp=%h", name, mem_addr, res); end
      n_cmp++;
      if (mem_we !== is_sw) begin n_bad++; $display("FAIL %s mem_we: got=%b exp=%b", name, mem_we, is_sw); end
      if (is_sw) begin
        n_cmp++;
        if (mem_wdata !== exp_wd) begin n_bad++; $display("FAIL %s mem_wdata: got=%h exp=%h", name, mem_wdata, exp_wd); end
      end
      if (i == delay - 1) begin mem_ack = 1'b1; mem_rdata = rdata; end
      step();
    end
    mem_ack = 1'b0; mem_rdata = 32'h0;
    sb_drain(name);
    n_cmp++;
    if (mem_req !== 1'b0) begin n_bad++; $display("FAIL %s mem_req after ack: got=%b exp=0", name, mem_req); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL %s in_ready after ack: got=%b exp=1", name, in_ready); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({reg_a, reg_b} !== 64'h0) begin n_bad++; $display("FAIL reset regs: got=%h_%h exp=0", reg_a, reg_b); end
    n_cmp++;
    if (pc !== 16'h0) begin n_bad++; $display("FAIL reset pc: got=%h exp=0", pc); end
    n_cmp++;
    if ({mem_req, mem_we, trap, retire_cnt, status_flags} !== '0) begin
      n_bad++; $display("FAIL reset ctl: got=%b%b%b cnt=%h fl=%b exp=0", mem_req, mem_we, trap, retire_cnt, status_flags);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got=%b exp=1", in_ready); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu_commit();
    issue_alu("addi_rt0", mk_i(6'h08, 5'd0, 5'd0, 6'h05), 32'h5, 3'b000);
    n_cmp++;
    if (reg_a !== 32'h5) begin n_bad++; $display("FAIL addi reg_a literal: got=%h exp=5", reg_a); end
    issue_alu("addi_rt7", mk_i(6'h08, 5'd7, 5'd0, 6'h09), 32'h9, 3'b010);
    issue_alu("add_rd1", mk_i(6'h00, 5'd0, 5'd1, 6'h20), 32'h77, 3'b000);
    issue_alu("ori_rt1", mk_i(6'h0D, 5'd1, 5'd0, 6'h00), 32'hAB, 3'b001);
    issue_alu("xori_rt0", mk_i(6'h0E, 5'd0, 5'd0, 6'h00), 32'hC0DE, 3'b000);
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_branch();
    logic [31:0] ofs;
    ofs = {16'h0, 16'(16'd10 - m_pc - 16'd1)};
    issue_alu("beq_to10", mk_i(6'h04, 5'd0, 5'd0, 6'h00) | ofs[15:0], ofs, 3'b000);
    issue_alu("beq_back", mk_i(6'h04, 5'd0, 5'd0, 6'h00), 32'h0000FFFE, 3'b000);
    n_cmp++;
    if (pc !== 16'd9) begin n_bad++; $display("FAIL beq pc literal: got=%0d exp=9", pc); end
    issue_alu("bne_taken", mk_i(6'h05, 5'd0, 5'd0, 6'h00), 32'h0, 3'b000);
    issue_alu("bne_not", mk_i(6'h05, 5'd0, 5'd0, 6'h00), 32'h0000_0020, 3'b001);
    n_cmp++;
    if (pc !== 16'd11) begin n_bad++; $display("FAIL bne pc literal: got=%0d exp=11", pc); end
    ofs = {16'h0, 16'(16'hFFFF - m_pc - 16'd1)};
    issue_alu("beq_top", mk_i(6'h04, 5'd0, 5'd0, 6'h00), ofs, 3'b000);
    issue_alu("pc_wrap", mk_i(6'h0C, 5'd9, 5'd0, 6'h00), 32'h1, 3'b000);
    n_cmp++;
    if (pc !== 16'd0) begin n_bad++; $display("FAIL pc wrap literal: got=%h exp=0", pc); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_load();
    issue_mem("lw_rt1", mk_i(6'h23, 5'd1, 5'd0, 6'h00), 32'h40, 3'b010, 32'hDEAD, 3);
    n_cmp++;
    if (reg_b !== 32'hDEAD) begin n_bad++; $display("FAIL lw reg_b literal: got=%h exp=DEAD", reg_b); end
    step();
  endtask

  task automatic test_store();
    issue_alu("addi_1234", mk_i(6'h08, 5'd0, 5'd0, 6'h00), 32'h1234, 3'b000);
    in_valid = 1'b0;
    issue_mem("sw_rt0", mk_i(6'h2B, 5'd0, 5'd0, 6'h00), 32'h80, 3'b000, 32'hBAD0BAD0, 1);
    issue_mem("sw_rt5", mk_i(6'h2B, 5'd5, 5'd0, 6'h00), 32'h84, 3'b001, 32'h0, 2);
    step();
  endtask

  task automatic test_mem_ack_idle();
    logic [31:0] a0;
    logic [PC_W-1:0] p0;
    a0 = reg_a; p0 = pc;
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    step();
    mem_ack = 1'b0;
    n_cmp++;
    if ({reg_a, pc, mem_req} !== {a0, p0, 1'b0}) begin
      n_bad++; $display("FAIL ack_idle: got=%h/%h/%b exp=%h/%h/0", reg_a, pc, mem_req, a0, p0);
    end
  endtask

  task automatic test_back_to_back();
    // Long enough burst to wrap the narrow retire counter
    for (int i = 0; i < 20; i++)
      issue_alu("b2b", mk_i(6'h09, 5'(i % 2), 5'd0, 6'h00), 32'h100 + 32'(i), 3'(i));
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    logic [31:0] ins;
    ins = mk_i(6'h00, 5'd0, 5'd0, 6'h20);
`ifdef ALU_WB_TRAP_EN
    m_fl = 3'b100;
    in_valid = 1'b1; instruction = ins; result = 32'h8000_0000; flags = 3'b100;
    step();
    flags = 3'b000;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({trap, in_ready} !== 2'b10) begin n_bad++; $display("FAIL trap hold: got=%b%b exp=10", trap, in_ready); end
      n_cmp++;
      if ({reg_a, reg_b, pc, retire_cnt, status_flags} !== {m_a, m_b, m_pc, m_cnt, m_fl}) begin
        n_bad++; $display("FAIL trap frozen: got=%h %h %h %h %b exp=%h %h %h %h %b", reg_a, reg_b, pc, retire_cnt,
                          status_flags, m_a, m_b, m_pc, m_cnt, m_fl);
      end
      step();
    end
    in_valid = 1'b0;
    trap_clr = 1'b1;
    step();
    trap_clr = 1'b0;
    m_pc = m_pc + 16'd1;
    n_cmp++;
    if ({trap, in_ready, pc} !== {1'b0, 1'b1, m_pc}) begin
      n_bad++; $display("FAIL trap clear: got=%b%b pc=%h exp=01 pc=%h", trap, in_ready, pc, m_pc);
    end
`else
    issue_alu("add_ovf", ins, 32'h8000_0000, 3'b100);
    in_valid = 1'b0;
    n_cmp++;
    if (trap !== 1'b0) begin n_bad++; $display("FAIL trap tied: got=%b exp=0", trap); end
`endif
    step();
  endtask

  task automatic test_reset_midrun();
    in_valid = 1'b1; instruction = mk_i(6'h23, 5'd0, 5'd0, 6'h00); result = 32'h44;
    step();
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (mem_req !== 1'b1) begin n_bad++; $display("FAIL midrun pre mem_req: got=%b exp=1", mem_req); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({reg_a, reg_b, pc, mem_req, in_ready} !== {64'h0, 16'h0, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL midrun reset: got=%h %h %h %b %b exp=0 0 0 0 1", reg_a, reg_b, pc, mem_req, in_ready);
    end
    m_a = '0; m_b = '0; m_pc = '0; m_cnt = '0; m_fl = '0;
    sb.delete();
    step();
    rst_n = 1'b1;
    step();
    issue_alu("post_reset", mk_i(6'h08, 5'd1, 5'd0, 6'h00), 32'h99, 3'b000);
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_alu_commit();
    test_branch();
    test_load();
    test_store();
    test_mem_ack_idle();
    test_back_to_back();
    test_overflow();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
